// File: rtl/match_pkg.sv
// match_pkg: shared types and constants for the baccarat match controller.
// Holds the round-sequencing state encoding, counter width, default watchdog
// limit and the saturating-increment helper used by the score counters.
package match_pkg;

    localparam int CNT_W          = 4;
    localparam int WDOG_LIMIT_DEF = 12;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        DEAL      = 3'd2,
        SCORE     = 3'd3,
        HOLD      = 3'd4,
        MATCH_END = 3'd5
    } state_e;

    // Increment by one when en is set, sticking at the all-ones value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             en);
        sat_inc = (en && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/match_controller_if.sv
// match_controller_if: link between the match controller and the dealing FSM.
// master = controller side (drives reset/enable, reads round status and lights),
// slave  = dealing FSM side.
interface match_controller_if;

    logic round_done;
    logic player_win_light;
    logic dealer_win_light;
    logic round_rst_n;
    logic step_en;

    modport master (
        input  round_done, player_win_light, dealer_win_light,
        output round_rst_n, step_en
    );

    modport slave (
        output round_done, player_win_light, dealer_win_light,
        input  round_rst_n, step_en
    );

endinterface

// File: rtl/win_tally.sv
// win_tally: player/dealer/tie round counters for the match controller.
// Decodes the win lights on the SCORE cycle, saturates each counter at its
// maximum and flags when the updated player or dealer count reaches the
// match target. Ties never produce a match win.
module win_tally
    import match_pkg::*;
#(
    parameter int WINS_TO_MATCH = 5
) (
    input  logic             slow_clock,
    input  logic             resetb,
    input  logic             clr,
    input  logic             score,
    input  logic             player_light,
    input  logic             dealer_light,
    output logic [CNT_W-1:0] pwins,
    output logic [CNT_W-1:0] dwins,
    output logic [CNT_W-1:0] ties,
    output logic             win_p,
    output logic             win_d
);

    localparam logic [CNT_W-1:0] TARGET = CNT_W'(WINS_TO_MATCH);

    logic             p_inc, d_inc, t_inc;
    logic [CNT_W-1:0] pwins_nx, dwins_nx, ties_nx;

    // Light decode: one light is a win for that side, both is a tie,
    // neither is a void round that leaves every counter alone.
    always_comb begin
        p_inc    = score &  player_light & ~dealer_light;
        d_inc    = score & ~player_light &  dealer_light;
        t_inc    = score &  player_light &  dealer_light;
        pwins_nx = sat_inc(pwins, p_inc);
        dwins_nx = sat_inc(dwins, d_inc);
        ties_nx  = sat_inc(ties,  t_inc);
        win_p    = p_inc && (pwins_nx == TARGET);
        win_d    = d_inc && (dwins_nx == TARGET);
    end

    // Counter registers; cleared by reset or by the start of a new match.
    always_ff @(posedge slow_clock) begin
        if (!resetb || clr) begin
            pwins <= '0;
            dwins <= '0;
            ties  <= '0;
        end else begin
            pwins <= pwins_nx;
            dwins <= dwins_nx;
            ties  <= ties_nx;
        end
    end

endmodule

// File: rtl/match_controller.sv
// match_controller: sequences baccarat rounds on the dealing FSM and keeps
// the match score. The dealing FSM is held in reset between matches, pulsed
// through one reset cycle at each round start, and clock-enabled only while
// the round is being dealt. Optional watchdog: define MATCH_WDOG_EN to abort
// a round that never reaches END within WDOG_LIMIT deal cycles.
module match_controller
    import match_pkg::*;
#(
    parameter int WINS_TO_MATCH = 5,
    parameter int WDOG_LIMIT    = WDOG_LIMIT_DEF
) (
    input  logic                 slow_clock,
    input  logic                 resetb,
    input  logic                 deal_req,
    match_controller_if.master   dbus,
    output logic [CNT_W-1:0]     pwins,
    output logic [CNT_W-1:0]     dwins,
    output logic [CNT_W-1:0]     ties,
    output logic                 match_over,
    output logic                 match_player,
    output logic                 match_dealer,
    output logic                 fault
);

    localparam logic [2:0] ST_IDLE      = IDLE;
    localparam logic [2:0] ST_CLEAR     = CLEAR;
    localparam logic [2:0] ST_DEAL      = DEAL;
    localparam logic [2:0] ST_SCORE     = SCORE;
    localparam logic [2:0] ST_HOLD      = HOLD;
    localparam logic [2:0] ST_MATCH_END = MATCH_END;

    // Count value at which the last permitted deal cycle is running.
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_LIMIT - 1);

    logic [2:0] state, state_nx;
    logic       tally_clr, score_en, win_p, win_d, wdog_trip;

    assign tally_clr = (state == ST_MATCH_END) && deal_req;
    assign score_en  = (state == ST_SCORE);

    win_tally #(.WINS_TO_MATCH(WINS_TO_MATCH)) u_tally (
        .slow_clock   (slow_clock),
        .resetb       (resetb),
        .clr          (tally_clr),
        .score        (score_en),
        .player_light (dbus.player_win_light),
        .dealer_light (dbus.dealer_win_light),
        .pwins        (pwins),
        .dwins        (dwins),
        .ties         (ties),
        .win_p        (win_p),
        .win_d        (win_d)
    );

`ifdef MATCH_WDOG_EN
    logic [CNT_W-1:0] wdog_cnt;

    assign wdog_trip = (state == ST_DEAL) && !dbus.round_done && (wdog_cnt == WDOG_LAST);

    // Deal-cycle counter: zeroed in CLEAR so it starts fresh on DEAL entry.
    always_ff @(posedge slow_clock) begin
        if (!resetb || state == ST_CLEAR) wdog_cnt <= '0;
        else if (state == ST_DEAL)        wdog_cnt <= wdog_cnt + 1'b1;
    end

    // Fault flag: set on a watchdog abort, dropped by the next deal request.
    always_ff @(posedge slow_clock) begin
        if (!resetb)        fault <= 1'b0;
        else if (wdog_trip) fault <= 1'b1;
        else if (deal_req)  fault <= 1'b0;
    end
`else
    logic unused_wdog;

    assign unused_wdog = |WDOG_LAST;
    assign wdog_trip   = 1'b0;
    assign fault       = 1'b0;
`endif

    // Round sequencing; deal_req only matters in IDLE, HOLD and MATCH_END.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:      if (deal_req) state_nx = ST_CLEAR;
            ST_CLEAR:     state_nx = ST_DEAL;
            ST_DEAL: begin
                if (dbus.round_done) state_nx = ST_SCORE;
                else if (wdog_trip)  state_nx = ST_HOLD;
            end
            ST_SCORE:     state_nx = (win_p || win_d) ? ST_MATCH_END : ST_HOLD;
            ST_HOLD:      if (deal_req) state_nx = ST_CLEAR;
            ST_MATCH_END: if (deal_req) state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge slow_clock) begin
        if (!resetb) state <= ST_IDLE;
        else         state <= state_nx;
    end

    // Match winner flags, latched on the deciding SCORE cycle.
    always_ff @(posedge slow_clock) begin
        if (!resetb || tally_clr) begin
            match_player <= 1'b0;
            match_dealer <= 1'b0;
        end else if (score_en) begin
            if (win_p) match_player <= 1'b1;
            if (win_d) match_dealer <= 1'b1;
        end
    end

    // Moore outputs; the dealing FSM stays out of reset after a round so its
    // lights remain visible until the next round or match restart.
    always_comb begin
        dbus.round_rst_n = (state != ST_IDLE) && (state != ST_CLEAR);
        dbus.step_en     = (state == ST_DEAL);
        match_over       = (state == ST_MATCH_END);
    end

endmodule
